// File: rtl/pps_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pps_pkg
// Brief    : Shared types and constants for the PPS/time-of-day datapath.
//            Also consumed by the receiver status and software register maps.
// Revision : 1.0 - initial release
// ============================================================================
package pps_pkg;

   // Time-of-day discipline state, encoded as reported on stat_state
   typedef enum logic [1:0] {
      UNLOCKED = 2'd0,
      LOCKED   = 2'd1,
      HOLDOVER = 2'd2
   } tod_state_t;

   // Default seconds counter width
   localparam int unsigned C_DEFAULT_SEC_WIDTH = 48;

endpackage : pps_pkg
`default_nettype wire

// File: rtl/tod_event_capture.sv
`default_nettype none
// ============================================================================
// Module   : tod_event_capture
// Brief    : Rising-edge detector on a synchronous event level that latches
//            the current time of day and emits a one-cycle valid strobe.
// Revision : 1.0 - initial release
// ============================================================================
module tod_event_capture #(
   parameter int unsigned C_SEC_WIDTH  = 48,
   parameter int unsigned C_TICK_WIDTH = 27
) (
   input  logic                    aclk_i,
   input  logic                    aresetn_i,
   input  logic                    event_i,
   input  logic [C_SEC_WIDTH-1:0]  tod_sec_i,
   input  logic [C_TICK_WIDTH-1:0] tod_tick_i,
   output logic [C_SEC_WIDTH-1:0]  ts_sec_o,
   output logic [C_TICK_WIDTH-1:0] ts_tick_o,
   output logic                    ts_valid_o
);

   logic                    event_d_q;
   logic                    ts_valid_q;
   logic [C_SEC_WIDTH-1:0]  ts_sec_q;
   logic [C_TICK_WIDTH-1:0] ts_tick_q;
   logic                    w_rise;

   // tod inputs are the pre-update register values, so a capture on the same
   // edge as a tod update naturally records the old time
   assign w_rise = event_i && !event_d_q;

   // Edge history, capture registers and strobe
   always_ff @(posedge aclk_i or negedge aresetn_i) begin
      if (!aresetn_i) begin
         event_d_q  <= 1'b0;
         ts_valid_q <= 1'b0;
         ts_sec_q   <= '0;
         ts_tick_q  <= '0;
      end else begin
         event_d_q  <= event_i;
         ts_valid_q <= w_rise;
         if (w_rise) begin
            ts_sec_q  <= tod_sec_i;
            ts_tick_q <= tod_tick_i;
         end
      end
   end

   assign ts_sec_o   = ts_sec_q;
   assign ts_tick_o  = ts_tick_q;
   assign ts_valid_o = ts_valid_q;

endmodule : tod_event_capture
`default_nettype wire

// File: rtl/pps_tod_counter.sv
`default_nettype none
// ============================================================================
// Module   : pps_tod_counter
// Brief    : PPS-disciplined time-of-day counter with holdover, deferred
//            seconds load and event timestamping.
// Revision : 1.0 - initial release
// ============================================================================
module pps_tod_counter
   import pps_pkg::*;
#(
   parameter  int unsigned C_CLOCK_FREQUENCY  = 125000000,
   parameter  int unsigned C_HOLDOVER_SECONDS = 4,
   parameter  int unsigned C_SEC_WIDTH        = C_DEFAULT_SEC_WIDTH,
   localparam int unsigned TW                 = $clog2(C_CLOCK_FREQUENCY)
) (
   input  logic                   aclk,
   input  logic                   aresetn,
   input  logic                   pps_in,
   input  logic                   pps_valid,
   input  logic [C_SEC_WIDTH-1:0] tod_load_sec,
   input  logic                   tod_load_valid,
   output logic                   tod_load_ready,
   input  logic                   event_in,
   output logic [C_SEC_WIDTH-1:0] ts_sec,
   output logic [TW-1:0]          ts_tick,
   output logic                   ts_valid,
   output logic [C_SEC_WIDTH-1:0] tod_sec,
   output logic [TW-1:0]          tod_tick,
   output logic                   pps_aligned,
   output logic [1:0]             stat_state,
   output logic [15:0]            stat_realign_cnt
);

   localparam logic [TW-1:0] C_TICK_MAX   = TW'(C_CLOCK_FREQUENCY - 1);
   localparam logic [3:0]    C_HOLD_LIMIT = 4'(C_HOLDOVER_SECONDS);

   tod_state_t             state_q, state_d;
   logic [TW-1:0]          tick_q, tick_d;
   logic [C_SEC_WIDTH-1:0] sec_q, sec_d;
   logic [C_SEC_WIDTH-1:0] load_sec_q, load_sec_d;
   logic                   load_pend_q, load_pend_d;
   logic [3:0]             miss_q, miss_d;
   logic [15:0]            realign_q, realign_d;
   logic                   aligned_q, aligned_d;
   logic                   w_pps_acc;
   logic                   w_wrap;

   assign w_pps_acc = pps_in && pps_valid;
   assign w_wrap    = (tick_q == C_TICK_MAX);

   // Counter, load, miss and realign next-state; an accepted PPS overrides the wrap
   always_comb begin
      tick_d      = tick_q + 1'b1;
      sec_d       = sec_q;
      load_pend_d = load_pend_q;
      load_sec_d  = load_sec_q;
      miss_d      = miss_q;
      realign_d   = realign_q;
      aligned_d   = w_pps_acc || w_wrap;

      if (w_pps_acc) begin
         tick_d = '0;
         sec_d  = load_pend_q ? load_sec_q : sec_q + 1'b1;
         miss_d = 4'd0;
      end else if (w_wrap) begin
         tick_d = '0;
         sec_d  = sec_q + 1'b1;
         if (miss_q != 4'hF) begin
            miss_d = miss_q + 1'b1;
         end
      end

      // A load only becomes pending after its transfer edge, so a PPS in the
      // transfer cycle still sees no pending value and uses sec+1
      if (w_pps_acc && load_pend_q) begin
         load_pend_d = 1'b0;
      end else if (tod_load_valid && !load_pend_q) begin
         load_pend_d = 1'b1;
         load_sec_d  = tod_load_sec;
      end

      if (w_pps_acc && !w_wrap && (state_q != UNLOCKED) && (realign_q != 16'hFFFF)) begin
         realign_d = realign_q + 1'b1;
      end
   end

   // Discipline FSM next-state, driven by accepted PPS and the next miss count
   always_comb begin
      state_d = state_q;
      case (state_q)
         UNLOCKED: begin
            if (w_pps_acc) state_d = LOCKED;
         end
         LOCKED: begin
            if (!w_pps_acc && (miss_d == 4'd1)) state_d = HOLDOVER;
         end
         HOLDOVER: begin
            if (w_pps_acc)                    state_d = LOCKED;
            else if (miss_d >= C_HOLD_LIMIT)  state_d = UNLOCKED;
         end
         default: state_d = UNLOCKED;
      endcase
   end

   // FSM state register
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) state_q <= UNLOCKED;
      else          state_q <= state_d;
   end

   // Datapath registers
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         tick_q      <= '0;
         sec_q       <= '0;
         load_sec_q  <= '0;
         load_pend_q <= 1'b0;
         miss_q      <= 4'd0;
         realign_q   <= 16'd0;
         aligned_q   <= 1'b0;
      end else begin
         tick_q      <= tick_d;
         sec_q       <= sec_d;
         load_sec_q  <= load_sec_d;
         load_pend_q <= load_pend_d;
         miss_q      <= miss_d;
         realign_q   <= realign_d;
         aligned_q   <= aligned_d;
      end
   end

   tod_event_capture #(
      .C_SEC_WIDTH  (C_SEC_WIDTH),
      .C_TICK_WIDTH (TW)
   ) u_event_capture (
      .aclk_i     (aclk),
      .aresetn_i  (aresetn),
      .event_i    (event_in),
      .tod_sec_i  (sec_q),
      .tod_tick_i (tick_q),
      .ts_sec_o   (ts_sec),
      .ts_tick_o  (ts_tick),
      .ts_valid_o (ts_valid)
   );

   assign tod_sec          = sec_q;
   assign tod_tick         = tick_q;
   assign tod_load_ready   = !load_pend_q;
   assign pps_aligned      = aligned_q;
   assign stat_state       = state_q;
   assign stat_realign_cnt = realign_q;

endmodule : pps_tod_counter
`default_nettype wire

// File: tb/tb_pps_tod_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_pps_tod_counter
// Brief    : Directed self-checking bench for pps_tod_counter at F = 100.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pps_tod_counter;

   logic        aclk = 1'b0;
   logic        aresetn = 1'b0;
   logic        pps_in = 1'b0;
   logic        pps_valid = 1'b0;
   logic [47:0] tod_load_sec = '0;
   logic        tod_load_valid = 1'b0;
   logic        tod_load_ready;
   logic        event_in = 1'b0;
   logic [47:0] ts_sec;
   logic [6:0]  ts_tick;
   logic        ts_valid;
   logic [47:0] tod_sec;
   logic [6:0]  tod_tick;
   logic        pps_aligned;
   logic [1:0]  stat_state;
   logic [15:0] stat_realign_cnt;

   int n_checks = 0;
   int n_errors = 0;

   pps_tod_counter #(
      .C_CLOCK_FREQUENCY  (100),
      .C_HOLDOVER_SECONDS (4),
      .C_SEC_WIDTH        (48)
   ) dut (
      .aclk             (aclk),
      .aresetn          (aresetn),
      .pps_in           (pps_in),
      .pps_valid        (pps_valid),
      .tod_load_sec     (tod_load_sec),
      .tod_load_valid   (tod_load_valid),
      .tod_load_ready   (tod_load_ready),
      .event_in         (event_in),
      .ts_sec           (ts_sec),
      .ts_tick          (ts_tick),
      .ts_valid         (ts_valid),
      .tod_sec          (tod_sec),
      .tod_tick         (tod_tick),
      .pps_aligned      (pps_aligned),
      .stat_state       (stat_state),
      .stat_realign_cnt (stat_realign_cnt)
   );

   always #5 aclk = ~aclk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance n rising edges and settle 1 time unit past the last one
   task automatic step(input int n);
      repeat (n) @(posedge aclk);
      #1;
   endtask

   // One-cycle PPS pulse (pps_valid left as set by the caller)
   task automatic pulse_pps();
      pps_in = 1'b1;
      step(1);
      pps_in = 1'b0;
   endtask

   initial begin
      // ---------------- reset values ----------------
      step(3);
      check("rst_tick",    tod_tick, 0);
      check("rst_sec",     tod_sec, 0);
      check("rst_state",   stat_state, 0);
      check("rst_ready",   tod_load_ready, 1);
      check("rst_aligned", pps_aligned, 0);
      check("rst_tsv",     ts_valid, 0);
      check("rst_realign", stat_realign_cnt, 0);
      aresetn = 1'b1;

      // ---------------- free run, no PPS ----------------
      step(1);
      check("fr_tick1",    tod_tick, 1);
      check("fr_align1",   pps_aligned, 0);
      step(98);
      check("fr_tick99",   tod_tick, 99);
      check("fr_sec0",     tod_sec, 0);
      step(1);
      check("fr_wrap_tick", tod_tick, 0);
      check("fr_wrap_sec",  tod_sec, 1);
      check("fr_wrap_al",   pps_aligned, 1);
      check("fr_state",     stat_state, 0);
      step(1);
      check("fr_al_off",    pps_aligned, 0);

      // ---------------- lock: PPS at tick 37 then on time ----------------
      pps_valid = 1'b1;
      step(36);
      check("lk_tick37",   tod_tick, 37);
      pulse_pps();
      check("lk_tick0",    tod_tick, 0);
      check("lk_sec",      tod_sec, 2);
      check("lk_state",    stat_state, 1);
      check("lk_realign",  stat_realign_cnt, 0);
      check("lk_al",       pps_aligned, 1);
      step(99);
      check("lk_pps_at99", tod_tick, 99);
      pulse_pps();
      check("lk2_sec",     tod_sec, 3);
      check("lk2_tick",    tod_tick, 0);
      check("lk2_realign", stat_realign_cnt, 0);

      // ---------------- load while LOCKED ----------------
      tod_load_sec = 48'h123456;
      tod_load_valid = 1'b1;
      step(1);
      tod_load_valid = 1'b0;
      check("ld_ready_lo", tod_load_ready, 0);
      step(98);
      check("ld_ready_lo2", tod_load_ready, 0);
      check("ld_sec_old",   tod_sec, 3);
      pulse_pps();
      check("ld_sec_new",   tod_sec, 48'h123456);
      check("ld_tick",      tod_tick, 0);
      check("ld_ready_hi",  tod_load_ready, 1);

      // load coincident with PPS waits for the following PPS
      step(99);
      tod_load_sec = 48'hABCDEF;
      tod_load_valid = 1'b1;
      pulse_pps();
      tod_load_valid = 1'b0;
      check("ldc_sec_inc",  tod_sec, 48'h123457);
      check("ldc_ready",    tod_load_ready, 0);
      step(99);
      pulse_pps();
      check("ldc_sec_new",  tod_sec, 48'hABCDEF);
      check("ldc_ready_hi", tod_load_ready, 1);

      // set sec to 5 for the event test
      tod_load_sec = 48'd5;
      tod_load_valid = 1'b1;
      step(1);
      tod_load_valid = 1'b0;
      step(98);
      pulse_pps();
      check("ev_pre_sec",  tod_sec, 5);

      // ---------------- event coincident with PPS ----------------
      step(99);
      event_in = 1'b1;
      pulse_pps();
      check("ev_ts_sec",   ts_sec, 5);
      check("ev_ts_tick",  ts_tick, 99);
      check("ev_tsv",      ts_valid, 1);
      check("ev_tod_sec",  tod_sec, 6);
      check("ev_tod_tick", tod_tick, 0);
      event_in = 1'b0;
      step(1);
      check("ev_tsv_off",  ts_valid, 0);
      // back-to-back edges one cycle apart
      event_in = 1'b1;
      step(1);
      check("bb1_tsv",     ts_valid, 1);
      check("bb1_tick",    ts_tick, 1);
      event_in = 1'b0;
      step(1);
      check("bb_gap_tsv",  ts_valid, 0);
      event_in = 1'b1;
      step(1);
      check("bb2_tsv",     ts_valid, 1);
      check("bb2_tick",    ts_tick, 3);
      check("bb2_sec",     ts_sec, 6);
      event_in = 1'b0;

      // ---------------- holdover ----------------
      step(95);
      check("ho_tick99",   tod_tick, 99);
      check("ho_locked",   stat_state, 1);
      step(1);
      check("ho_enter",    stat_state, 2);
      check("ho_sec7",     tod_sec, 7);
      step(100);
      check("ho_stay",     stat_state, 2);
      step(50);
      check("ho_tick50",   tod_tick, 50);
      pulse_pps();
      check("ho_relock",   stat_state, 1);
      check("ho_realign",  stat_realign_cnt, 1);
      check("ho_sec9",     tod_sec, 9);
      check("ho_tick0",    tod_tick, 0);

      // ---------------- pps_valid low: pulses ignored ----------------
      pps_valid = 1'b0;
      tod_load_sec = 48'h777;
      tod_load_valid = 1'b1;
      step(1);
      tod_load_valid = 1'b0;
      step(98);
      pulse_pps();
      check("pv_sec10",    tod_sec, 10);
      check("pv_ho",       stat_state, 2);
      check("pv_ready",    tod_load_ready, 0);
      step(99);
      pulse_pps();
      check("pv_sec11",    tod_sec, 11);
      step(100);
      check("pv_miss3",    stat_state, 2);
      step(100);
      check("pv_unlock",   stat_state, 0);
      check("pv_sec13",    tod_sec, 13);
      check("pv_ready2",   tod_load_ready, 0);
      check("pv_realign",  stat_realign_cnt, 1);
      pps_valid = 1'b1;
      step(50);
      pulse_pps();
      check("pv_ld_sec",   tod_sec, 48'h777);
      check("pv_lock",     stat_state, 1);
      check("pv_realign2", stat_realign_cnt, 1);
      check("pv_ready_hi", tod_load_ready, 1);

      // ---------------- reset mid-operation ----------------
      tod_load_sec = 48'h999;
      tod_load_valid = 1'b1;
      step(1);
      tod_load_valid = 1'b0;
      check("mr_ready_lo", tod_load_ready, 0);
      aresetn = 1'b0;
      #1;
      check("mr_tick",     tod_tick, 0);
      check("mr_sec",      tod_sec, 0);
      check("mr_state",    stat_state, 0);
      check("mr_ready",    tod_load_ready, 1);
      check("mr_realign",  stat_realign_cnt, 0);
      check("mr_tsv",      ts_valid, 0);
      check("mr_ts_sec",   ts_sec, 0);
      aresetn = 1'b1;
      step(1);
      check("mr_tick1",    tod_tick, 1);
      step(98);
      pulse_pps();
      check("mr_no_load",  tod_sec, 1);
      check("mr_lock",     stat_state, 1);

      // ---------------- seconds wrap at 2^48-1 ----------------
      tod_load_sec = 48'hFFFF_FFFF_FFFF;
      tod_load_valid = 1'b1;
      step(1);
      tod_load_valid = 1'b0;
      step(98);
      pulse_pps();
      check("sw_max",      tod_sec, 48'hFFFF_FFFF_FFFF);
      pps_valid = 1'b0;
      step(100);
      check("sw_zero",     tod_sec, 0);
      check("sw_tick",     tod_tick, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule : tb_pps_tod_counter
`default_nettype wire

// File: doc/pps_tod_counter.md
# pps_tod_counter

Time-of-day counter disciplined by the 1PPS pulse from the PPS receiver; sits directly downstream of it in the core clock domain. Maintains a seconds count and a sub-second tick count, realigns to the recovered PPS, and free-runs through short PPS outages (holdover). It also accepts a software-loaded seconds value that takes effect on the next PPS, and timestamps an external event strobe.

## Interface
- C_CLOCK_FREQUENCY, 125000000, core clock frequency in Hz; ticks per second
- C_HOLDOVER_SECONDS, 4, missed PPS seconds tolerated in HOLDOVER before dropping to UNLOCKED (1..15)
- C_SEC_WIDTH, 48, seconds counter width

Ports:
- aclk  in  1  core clock, same domain as the PPS receiver output
- aresetn  in  1  asynchronous, active-low reset
- pps_in  in  1  one-cycle PPS pulse from the receiver
- pps_valid  in  1  receiver lock status; pps_in is ignored while low
- tod_load_sec  in  C_SEC_WIDTH  seconds value to apply at next PPS
- tod_load_valid  in  1  load request
- tod_load_ready  out  1  high when no load is pending
- event_in  in  1  synchronous event level; rising edge is timestamped
- ts_sec  out  C_SEC_WIDTH  captured seconds
- ts_tick  out  TW  captured tick, TW = $clog2(C_CLOCK_FREQUENCY)
- ts_valid  out  1  one-cycle capture strobe
- tod_sec  out  C_SEC_WIDTH  current seconds
- tod_tick  out  TW  current tick, 0..F-1 (F = C_CLOCK_FREQUENCY)
- pps_aligned  out  1  local second-boundary pulse
- stat_state  out  2  0 UNLOCKED, 1 LOCKED, 2 HOLDOVER
- stat_realign_cnt  out  16  saturating count of off-time PPS realignments

## Operation
- An accepted PPS is pps_in && pps_valid.
- The tick increments every cycle. On tick == F-1 the tick goes to 0 and sec increments, wrapping at 2^C_SEC_WIDTH-1 → 0.
- An accepted PPS forces tick ← 0 and sec ← (load pending ? loaded value : sec+1) on the same edge. This replaces the normal wrap; it never causes a double increment.
- A PPS is on-time when it coincides with tick == F-1. Otherwise it is a realign: in LOCKED or HOLDOVER, stat_realign_cnt increments, saturating at 0xFFFF. No increment while UNLOCKED.
- The miss counter (4 bit) is cleared on every accepted PPS. It increments on each natural wrap (tick == F-1 with no accepted PPS).
- State machine:
  - UNLOCKED → LOCKED on an accepted PPS.
  - LOCKED → HOLDOVER when the miss counter becomes 1.
  - HOLDOVER → LOCKED on an accepted PPS.
  - HOLDOVER → UNLOCKED when the miss counter reaches C_HOLDOVER_SECONDS.
  - pps_valid low does not change state directly; it only suppresses PPS.
- Load handshake:
  - A transfer occurs when tod_load_valid && tod_load_ready. The value is captured and ready drops on the next edge.
  - The pending value is applied on the next accepted PPS strictly after the transfer cycle, in any state. ready returns high the cycle after it is applied.
  - A transfer and an accepted PPS in the same cycle: the PPS uses sec+1; the load waits for the following PPS.
- Event capture: the rising edge of event_in (event_in && !event_d) registers the current {tod_sec, tod_tick} into ts_*. ts_valid is high on the next cycle. If the same edge also updates tod, the pre-update value is captured.

## Timing
- Reset values: tod_sec 0, tod_tick 0, state UNLOCKED, tod_load_ready 1, ts_sec/ts_tick 0, ts_valid 0, pps_aligned 0, stat_realign_cnt 0, miss counter 0, event_d 0.
- Reset mid-operation discards any pending load and clears all state asynchronously.
- Latencies:
  - PPS accepted at edge k → tod_tick == 0 after edge k.
  - pps_aligned is registered: high in exactly the cycles where tick has just entered 0 by wrap or PPS. It is never high in the first cycle after reset.
  - Event edge at edge k → ts_valid high after edge k+1 for one cycle.
- Back-to-back events one cycle apart each produce a strobe. ts_* always holds the latest capture.

## Structure
- Package pps_pkg: the tod_state_t enum (UNLOCKED/LOCKED/HOLDOVER) and the default C_SEC_WIDTH constant. It is shared with the receiver status and software register maps.
- One sub-module: tod_event_capture (edge detect, capture registers, ts_valid strobe). Counter, FSM and load logic stay in the top.

## Test plan
Simulate with F = 100.
- Reset, no PPS: tick wraps 99 → 0 and sec 0 → 1 after 100 cycles; state stays UNLOCKED; pps_aligned pulses every 100 cycles starting at cycle 100.
- PPS at tick 37, then every 100 cycles: tick → 0 after the first PPS, state LOCKED, stat_realign_cnt 0, and later PPS arrive at tick 99.
- LOCKED, then PPS stops: HOLDOVER after 1 missed wrap, UNLOCKED after 4 missed wraps. A PPS during HOLDOVER at tick 50 → LOCKED with stat_realign_cnt = 1.
- Load 0x123456 while LOCKED: ready low until the next PPS, then sec = 0x123456 and ready high one cycle later. A load in the same cycle as a PPS is applied at the following PPS.
- Event edge coincident with the PPS edge (tick 99, sec 5): ts = {5, 99}, ts_valid one cycle later, tod = {6, 0}.
- pps_valid held low with pps_in pulses: pulses are ignored, the pending load stays pending, and the state follows the miss counter.
